// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the memory-port arbiter.
package ecap5_dproc_pkg;

    // Arbiter bus-cycle states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2
    } mem_arb_state_t;

    // Which requester owns the transaction currently on the bus.
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } mem_arb_owner_t;

    // Instruction fetches always move a full 32-bit word.
    localparam logic [3:0] WB_SEL_WORD = 4'hF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating cycle counter that flags the cycle in which an outstanding bus
// transaction reaches its time limit. o_expired is asserted one cycle before
// the count reaches LIMIT, so the registered abort lands LIMIT+1 cycles after
// the grant.
module mem_arb_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_count;

    // Count busy cycles; cleared on each new grant, stops at the limit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != W'(LIMIT))) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = i_enable && (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single pipelined Wishbone master port between instruction
// fetch (IF) and load/store (LS). LS has priority, but after MAX_LS_STREAK
// consecutive LS grants taken while IF was waiting, IF is served once.
// One transaction is outstanding at a time; a watchdog aborts transactions
// that are never acknowledged.
//
// Requester handshake: a requester raises *_req_i with its fields and keeps
// them stable until it sees *_ack_o or *_err_o (a one-cycle pulse). Dropping
// the request mid-transaction does not cancel it. A requester that has no
// further work must drop *_req_i in the cycle the pulse is visible, otherwise
// the still-high request is taken as a new one.
module mem_arbiter
    import ecap5_dproc_pkg::*;
#(
    parameter int MAX_LS_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           if_req_i,
    input  logic [31:0]    if_addr_i,
    input  logic           ls_req_i,
    input  logic [31:0]    ls_addr_i,
    input  logic           ls_we_i,
    input  logic [3:0]     ls_sel_i,
    input  logic [31:0]    ls_data_i,
    output logic           if_ack_o,
    output logic           ls_ack_o,
    output logic           if_err_o,
    output logic           ls_err_o,
    output logic [31:0]    rdata_o,
    output logic [31:0]    wb_adr_o,
    output logic [31:0]    wb_dat_o,
    output logic [3:0]     wb_sel_o,
    output logic           wb_we_o,
    output logic           wb_stb_o,
    output logic           wb_cyc_o,
    input  logic [31:0]    wb_dat_i,
    input  logic           wb_ack_i,
    input  logic           wb_stall_i,
    output mem_arb_state_t dbg_state_o
);

    localparam int SW = $clog2(MAX_LS_STREAK + 1);

    mem_arb_state_t r_state;
    mem_arb_state_t w_next_state;
    mem_arb_owner_t r_owner;
    logic [SW-1:0]  r_streak;
    logic           w_streak_full;
    logic           w_grant;
    logic           w_grant_ls;
    logic           w_complete;
    logic           w_abort;
    logic           w_busy;
    logic           w_expired;

    logic [31:0]    r_adr;
    logic [31:0]    r_dat;
    logic [3:0]     r_sel;
    logic           r_we;
    logic           r_stb;
    logic           r_cyc;
    logic [31:0]    r_rdata;
    logic           r_if_ack;
    logic           r_ls_ack;
    logic           r_if_err;
    logic           r_ls_err;

    assign w_streak_full = (r_streak == SW'(MAX_LS_STREAK));
    assign w_busy        = (r_state != IDLE);

    mem_arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_clear  (w_grant),
        .i_enable (w_busy),
        .o_expired(w_expired)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, grant decision and completion/abort events.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_ls   = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req_i || ls_req_i) begin
                    w_grant      = 1'b1;
                    w_grant_ls   = ls_req_i && !(if_req_i && w_streak_full);
                    w_next_state = REQUEST;
                end
            end
            REQUEST: begin
                // An ack can only accompany the cycle the strobe is accepted;
                // it beats a coinciding watchdog expiry.
                if (!wb_stall_i && wb_ack_i) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end else if (!wb_stall_i) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (wb_ack_i) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // LS streak: counts LS grants that made a waiting IF request wait longer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_streak <= '0;
        end else if (w_grant) begin
            if (w_grant_ls && if_req_i) begin
                if (!w_streak_full) begin
                    r_streak <= r_streak + SW'(1);
                end
            end else begin
                r_streak <= '0;
            end
        end
    end

    // Registered bus outputs, captured request fields and requester pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner  <= OWNER_IF;
            r_adr    <= '0;
            r_dat    <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_stb    <= 1'b0;
            r_cyc    <= 1'b0;
            r_rdata  <= '0;
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            r_if_err <= 1'b0;
            r_ls_err <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            r_if_err <= 1'b0;
            r_ls_err <= 1'b0;
            if (w_grant) begin
                r_owner <= w_grant_ls ? OWNER_LS : OWNER_IF;
                r_adr   <= w_grant_ls ? ls_addr_i : if_addr_i;
                r_dat   <= w_grant_ls ? ls_data_i : 32'h0;
                r_sel   <= w_grant_ls ? ls_sel_i : WB_SEL_WORD;
                r_we    <= w_grant_ls ? ls_we_i : 1'b0;
                r_stb   <= 1'b1;
                r_cyc   <= 1'b1;
            end
            if ((r_state == REQUEST) && !wb_stall_i) begin
                r_stb <= 1'b0;
            end
            if (w_complete || w_abort) begin
                r_stb <= 1'b0;
                r_cyc <= 1'b0;
            end
            if (w_complete) begin
                r_rdata <= wb_dat_i;
                if (r_owner == OWNER_LS) begin
                    r_ls_ack <= 1'b1;
                end else begin
                    r_if_ack <= 1'b1;
                end
            end
            if (w_abort) begin
                if (r_owner == OWNER_LS) begin
                    r_ls_err <= 1'b1;
                end else begin
                    r_if_err <= 1'b1;
                end
            end
        end
    end

    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign wb_sel_o    = r_sel;
    assign wb_we_o     = r_we;
    assign wb_stb_o    = r_stb;
    assign wb_cyc_o    = r_cyc;
    assign rdata_o     = r_rdata;
    assign if_ack_o    = r_if_ack;
    assign ls_ack_o    = r_ls_ack;
    assign if_err_o    = r_if_err;
    assign ls_err_o    = r_ls_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled 1ns
// after the rising edge; the bench plays the Wishbone slave by hand.
module tb_mem_arbiter;
    import ecap5_dproc_pkg::*;

    logic           clk;
    logic           rst;
    logic           if_req;
    logic [31:0]    if_addr;
    logic           ls_req;
    logic [31:0]    ls_addr;
    logic           ls_we;
    logic [3:0]     ls_sel;
    logic [31:0]    ls_data;
    logic           if_ack_o;
    logic           ls_ack_o;
    logic           if_err_o;
    logic           ls_err_o;
    logic [31:0]    rdata_o;
    logic [31:0]    wb_adr_o;
    logic [31:0]    wb_dat_o;
    logic [3:0]     wb_sel_o;
    logic           wb_we_o;
    logic           wb_stb_o;
    logic           wb_cyc_o;
    logic [31:0]    wb_dat_i;
    logic           wb_ack_i;
    logic           wb_stall_i;
    mem_arb_state_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .MAX_LS_STREAK (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .ls_req_i   (ls_req),
        .ls_addr_i  (ls_addr),
        .ls_we_i    (ls_we),
        .ls_sel_i   (ls_sel),
        .ls_data_i  (ls_data),
        .if_ack_o   (if_ack_o),
        .ls_ack_o   (ls_ack_o),
        .if_err_o   (if_err_o),
        .ls_err_o   (ls_err_o),
        .rdata_o    (rdata_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_stall_i (wb_stall_i),
        .dbg_state_o(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    bit exp_ls [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int bad;

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_sel = '0; ls_data = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
        #2;
        // ---- reset state ----
        check("rst_cyc", 32'(wb_cyc_o), 32'h0);
        check("rst_stb", 32'(wb_stb_o), 32'h0);
        check("rst_we", 32'(wb_we_o), 32'h0);
        check("rst_sel", 32'(wb_sel_o), 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_acks", {30'h0, if_ack_o, ls_ack_o}, 32'h0);
        check("rst_errs", {30'h0, if_err_o, ls_err_o}, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        tick(); tick();
        rst = 1'b0;
        tick();

        // ---- single IF read, zero-wait slave ----
        if_req = 1'b1; if_addr = 32'h0000_1000;
        tick();                                  // N+1
        check("if1_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h3);
        check("if1_adr", wb_adr_o, 32'h0000_1000);
        check("if1_sel", 32'(wb_sel_o), 32'hF);
        check("if1_we", 32'(wb_we_o), 32'h0);
        check("if1_noack", 32'(if_ack_o), 32'h0);
        tick();                                  // N+2
        check("if1_wait", {30'h0, wb_cyc_o, wb_stb_o}, 32'h2);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick();                                  // N+3
        wb_ack_i = 1'b0; wb_dat_i = '0;
        check("if1_ack", 32'(if_ack_o), 32'h1);
        check("if1_ls_ack", 32'(ls_ack_o), 32'h0);
        check("if1_rdata", rdata_o, 32'hDEAD_BEEF);
        check("if1_cyc_low", 32'(wb_cyc_o), 32'h0);
        if_req = 1'b0;
        tick();
        check("if1_ack_pulse", 32'(if_ack_o), 32'h0);
        check("if1_idle", 32'(wb_cyc_o), 32'h0);

        // ---- simultaneous requests: LS write first, then IF ----
        if_req = 1'b1; if_addr = 32'h0000_3000;
        ls_req = 1'b1; ls_addr = 32'h0000_2000; ls_we = 1'b1; ls_sel = 4'h3; ls_data = 32'h1234_5678;
        tick();
        check("sim_ls_adr", wb_adr_o, 32'h0000_2000);
        check("sim_ls_we", 32'(wb_we_o), 32'h1);
        check("sim_ls_sel", 32'(wb_sel_o), 32'h3);
        check("sim_ls_dat", wb_dat_o, 32'h1234_5678);
        check("sim_ls_stb", 32'(wb_stb_o), 32'h1);
        tick();
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("sim_ls_ack", {30'h0, if_ack_o, ls_ack_o}, 32'h1);
        check("sim_ls_cyc", 32'(wb_cyc_o), 32'h0);
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        check("sim_if_adr", wb_adr_o, 32'h0000_3000);
        check("sim_if_we", 32'(wb_we_o), 32'h0);
        check("sim_if_sel", 32'(wb_sel_o), 32'hF);
        check("sim_if_stb", 32'(wb_stb_o), 32'h1);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        check("sim_if_ack", {30'h0, if_ack_o, ls_ack_o}, 32'h2);
        check("sim_if_rdata", rdata_o, 32'hCAFE_F00D);
        if_req = 1'b0;
        tick();

        // ---- starvation guard: 4 LS grants, 1 IF, then LS ----
        if_req = 1'b1; if_addr = 32'h0000_4000;
        ls_req = 1'b1; ls_addr = 32'h0000_5000; ls_we = 1'b0; ls_sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("starve%0d_adr", i), wb_adr_o, exp_ls[i] ? 32'h0000_5000 : 32'h0000_4000);
            tick();
            wb_ack_i = 1'b1; wb_dat_i = 32'(i);
            tick();
            wb_ack_i = 1'b0;
            check($sformatf("starve%0d_ack", i), {30'h0, if_ack_o, ls_ack_o},
                  exp_ls[i] ? 32'h1 : 32'h2);
            if (!exp_ls[i]) if_req = 1'b0;
            if (i == 5) ls_req = 1'b0;
        end
        tick();
        check("starve_idle", 32'(wb_cyc_o), 32'h0);

        // ---- ack in the strobe cycle skips WAIT ----
        ls_req = 1'b1; ls_addr = 32'h0000_A000;
        tick();
        check("skip_stb", 32'(wb_stb_o), 32'h1);
        wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_A5A5;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        check("skip_ack", 32'(ls_ack_o), 32'h1);
        check("skip_rdata", rdata_o, 32'hA5A5_A5A5);
        check("skip_cyc", 32'(wb_cyc_o), 32'h0);
        ls_req = 1'b0;
        tick();
        check("skip_ack_pulse", 32'(ls_ack_o), 32'h0);

        // ---- three stall cycles ----
        ls_req = 1'b1; ls_addr = 32'h0000_6000; ls_we = 1'b1; ls_sel = 4'hC; ls_data = 32'h1111_2222;
        tick();                                  // R1
        wb_stall_i = 1'b1;
        check("stall_r1_stb", 32'(wb_stb_o), 32'h1);
        tick();                                  // R2
        check("stall_r2_stb", 32'(wb_stb_o), 32'h1);
        check("stall_r2_adr", wb_adr_o, 32'h0000_6000);
        tick();                                  // R3
        check("stall_r3_stb", 32'(wb_stb_o), 32'h1);
        check("stall_r3_dat", wb_dat_o, 32'h1111_2222);
        tick();                                  // R4
        wb_stall_i = 1'b0;
        check("stall_r4_stb", 32'(wb_stb_o), 32'h1);
        check("stall_r4_sel", 32'(wb_sel_o), 32'hC);
        check("stall_r4_we", 32'(wb_we_o), 32'h1);
        tick();                                  // R5
        check("stall_wait", {30'h0, wb_cyc_o, wb_stb_o}, 32'h2);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("stall_ack", 32'(ls_ack_o), 32'h1);
        ls_req = 1'b0; ls_we = 1'b0; ls_sel = 4'hF;
        tick();

        // ---- timeout: never acknowledged ----
        ls_req = 1'b1; ls_addr = 32'h0000_7000;  // grant cycle G
        bad = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (ls_err_o || ls_ack_o || !wb_cyc_o) bad++;
        end
        check("to_quiet_until_g64", 32'(bad), 32'h0);
        tick();                                  // G+65
        check("to_err", 32'(ls_err_o), 32'h1);
        check("to_no_ack", 32'(ls_ack_o), 32'h0);
        check("to_cyc_drop", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        ls_req = 1'b0;
        tick();
        check("to_err_pulse", 32'(ls_err_o), 32'h0);

        // ---- ack on the expiry cycle wins ----
        ls_req = 1'b1; ls_addr = 32'h0000_7100;  // grant cycle G
        for (int k = 1; k <= 64; k++) begin
            tick();
        end                                      // G+64
        wb_ack_i = 1'b1; wb_dat_i = 32'h600D_0ACC;
        tick();                                  // G+65
        wb_ack_i = 1'b0; wb_dat_i = '0;
        check("edge_ack", 32'(ls_ack_o), 32'h1);
        check("edge_no_err", 32'(ls_err_o), 32'h0);
        check("edge_rdata", rdata_o, 32'h600D_0ACC);
        ls_req = 1'b0;
        tick();
        check("edge_no_late_err", {30'h0, ls_err_o, ls_ack_o}, 32'h0);

        // ---- asynchronous reset during WAIT ----
        ls_req = 1'b1; ls_addr = 32'h0000_8000;
        tick();
        tick();
        check("rstw_in_wait", 32'(dbg_state), 32'(WAIT));
        #2;
        rst = 1'b1;
        #1;
        check("rstw_async_bus", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("rstw_async_state", 32'(dbg_state), 32'(IDLE));
        ls_req = 1'b0;
        tick();
        check("rstw_no_resp", {28'h0, if_ack_o, ls_ack_o, if_err_o, ls_err_o}, 32'h0);
        rst = 1'b0;
        tick();
        check("rstw_after_release", {28'h0, if_ack_o, ls_ack_o, if_err_o, ls_err_o}, 32'h0);
        check("rstw_idle_cyc", 32'(wb_cyc_o), 32'h0);
        if_req = 1'b1; if_addr = 32'h0000_9000;
        tick();
        check("rstw_new_stb", 32'(wb_stb_o), 32'h1);
        check("rstw_new_adr", wb_adr_o, 32'h0000_9000);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h1357_9BDF;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        check("rstw_new_ack", 32'(if_ack_o), 32'h1);
        check("rstw_new_rdata", rdata_o, 32'h1357_9BDF);
        if_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
